// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl: start/busy/done sequencer for 2x2 stride-2 max pooling over a CHANNEL x HEIGHT x WIDTH map
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : run request, sampled only while idle
//   busy, done       : run in progress / one-cycle completion pulse
//   rd_en, rd_addr   : input RAM read strobe and address
//   rd_data          : input RAM data, one cycle after rd_en
//   wr_en, wr_addr, wr_data, wr_ready : pooled-output write handshake
module maxpool_seq_ctrl #(
    parameter int WIDTH   = 28,
    parameter int HEIGHT  = 28,
    parameter int CHANNEL = 6,
    parameter int IN_AW   = 13,
    parameter int OUT_AW  = 11,
    parameter int SIGNED  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready
);
    localparam int OW = WIDTH / 2;
    localparam int OH = HEIGHT / 2;
    localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int YW = (OH > 1) ? $clog2(OH) : 1;
    localparam int XW = (OW > 1) ? $clog2(OW) : 1;
    localparam logic [31:0] IN_PLANE  = 32'(HEIGHT * WIDTH);
    localparam logic [31:0] IN_ROW    = 32'(WIDTH);
    localparam logic [31:0] OUT_PLANE = 32'(OH * OW);
    localparam logic [31:0] OUT_ROW   = 32'(OW);

    typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] c;
    logic [YW-1:0] oy;
    logic [XW-1:0] ox;
    logic [1:0]    k;
    logic [7:0]    mx;
    logic          px_gt;
    logic [7:0]    px_max;
    logic          last_x, last_y, last_c;

    assign last_x = ox == XW'(OW - 1);
    assign last_y = oy == YW'(OH - 1);
    assign last_c = c == CW'(CHANNEL - 1);
    assign px_gt  = (SIGNED != 0) ? ($signed(rd_data) > $signed(mx)) : (rd_data > mx);
    assign px_max = px_gt ? rd_data : mx;
    assign rd_en  = state == RD;
    // {oy,k[1]} and {ox,k[0]} are 2*oy+dy and 2*ox+dx for the window pixel selected by k
    assign rd_addr = rd_en ? IN_AW'(32'(c) * IN_PLANE + 32'({oy, k[1]}) * IN_ROW + 32'({ox, k[0]})) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RD : IDLE;
            RD:      state_nx = (k == 2'd3) ? LAST : RD;
            LAST:    state_nx = WR;
            WR:      state_nx = !wr_ready ? WR : (last_x && last_y && last_c) ? DONE : RD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            c       <= '0;
            oy      <= '0;
            ox      <= '0;
            k       <= '0;
            mx      <= '0;
        end else begin
            done <= state == DONE;
            case (state)
                IDLE: if (start) begin
                    c    <= '0;
                    oy   <= '0;
                    ox   <= '0;
                    k    <= '0;
                    busy <= 1'b1;
                end
                RD: begin
                    k <= k + 2'd1;
                    // pixel k-1 arrives while k is presented; pixel 0 seeds the running max
                    if (k == 2'd1)      mx <= rd_data;
                    else if (k != 2'd0) mx <= px_max;
                end
                LAST: begin
                    wr_data <= px_max;
                    wr_addr <= OUT_AW'(32'(c) * OUT_PLANE + 32'(oy) * OUT_ROW + 32'(ox));
                    wr_en   <= 1'b1;
                end
                WR: if (wr_ready) begin
                    wr_en <= 1'b0;
                    ox    <= last_x ? '0 : ox + XW'(1);
                    if (last_x) oy <= last_y ? '0 : oy + YW'(1);
                    if (last_x && last_y && !last_c) c <= c + CW'(1);
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
